// File: rtl/touch_button_sequencer.sv
// ---------------------------------------------------------------------------
// touch_button_sequencer
//
// Turns touch-panel samples into three on-screen buttons (up, left, right)
// with press pulses and keyboard-style auto-repeat.
//
// Ports
//   iCLK           system clock, rising edge
//   iRSTN          asynchronous active-low reset
//   iREADY         panel sample strobe, asynchronous to iCLK
//   ix1/iy1        finger 1 coordinates (10/9 bits)
//   ix2/iy2        finger 2 coordinates (10/9 bits)
//   itouch_count   number of fingers in the sample
//   oButton_state  {1'b0, up, left, right}, buttons currently held
//   oPress         one-cycle press / auto-repeat pulses, same bit order
//   oTouch_active  high while a touch is in progress
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no finger on the panel, outputs held at zero
// ACTIVE | touch in progress; release counter runs between samples
// ---------------------------------------------------------------------------
module touch_button_sequencer #(
    parameter int RELEASE_TIMEOUT = 2_500_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter int CNT_W           = 25
) (
    input  logic       iCLK,
    input  logic       iRSTN,
    input  logic       iREADY,
    input  logic [9:0] ix1,
    input  logic [8:0] iy1,
    input  logic [9:0] ix2,
    input  logic [8:0] iy2,
    input  logic [1:0] itouch_count,
    output logic [3:0] oButton_state,
    output logic [3:0] oPress,
    output logic       oTouch_active
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    logic [2:0]       ready_d;
    logic [9:0]       cap_x1;
    logic [8:0]       cap_y1;
    logic [9:0]       cap_x2;
    logic [8:0]       cap_y2;
    logic [1:0]       cap_count;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] rpt_cnt;
    logic             repeating;

    logic             sample_ev;
    logic             leaving;
    logic [2:0]       hits;
    logic [3:0]       button_next;
    logic [CNT_W-1:0] rpt_last;

    // {up, left, right} for one finger; all bounds are exclusive.
    function automatic logic [2:0] zone_hits(input logic [9:0] x, input logic [8:0] y);
        logic y_ok;
        y_ok = (y > 9'd400);
        zone_hits = {y_ok && (x > 10'd0)   && (x < 10'd100),
                     y_ok && (x > 10'd600) && (x < 10'd700),
                     y_ok && (x > 10'd700) && (x < 10'd800)};
    endfunction

    always_comb begin
        // iREADY is asynchronous: ready_d[0] is the metastability stage,
        // the edge is detected between the two settled stages.
        sample_ev = ready_d[1] & ~ready_d[2];

        hits = ((cap_count != 2'd0) ? zone_hits(cap_x1, cap_y1) : 3'b000) |
               (cap_count[1]        ? zone_hits(cap_x2, cap_y2) : 3'b000);

        // A sample in the timeout cycle pre-empts the timeout.
        leaving = (state == ACTIVE) &&
                  (sample_ev ? (itouch_count == 2'd0) : (rel_cnt == REL_LAST));

        // Buttons drop in the same cycle the FSM returns to IDLE.
        button_next = ((state == ACTIVE) && !leaving) ? {1'b0, hits} : 4'b0000;

        rpt_last = repeating ? PERIOD_LAST : DELAY_LAST;
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            ready_d   <= '0;
            cap_x1    <= '0;
            cap_y1    <= '0;
            cap_x2    <= '0;
            cap_y2    <= '0;
            cap_count <= '0;
        end else begin
            ready_d <= {ready_d[1:0], iREADY};
            if (sample_ev) begin
                cap_x1    <= ix1;
                cap_y1    <= iy1;
                cap_x2    <= ix2;
                cap_y2    <= iy2;
                cap_count <= itouch_count;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state         <= IDLE;
            rel_cnt       <= '0;
            rpt_cnt       <= '0;
            repeating     <= 1'b0;
            oButton_state <= 4'b0000;
            oPress        <= 4'b0000;
            oTouch_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rel_cnt <= '0;
                    if (sample_ev && (itouch_count != 2'd0)) begin
                        state         <= ACTIVE;
                        oTouch_active <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (leaving) begin
                        state         <= IDLE;
                        oTouch_active <= 1'b0;
                        rel_cnt       <= '0;
                    end else if (sample_ev) begin
                        rel_cnt <= '0;
                    end else if (rel_cnt != CNT_MAX) begin
                        rel_cnt <= rel_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    oTouch_active <= 1'b0;
                    rel_cnt       <= '0;
                end
            endcase

            oButton_state <= button_next;

            // Any change of the held set restarts the repeat delay; only
            // newly set bits pulse on a change, so a release never pulses.
            if ((button_next != oButton_state) || (button_next == 4'b0000)) begin
                rpt_cnt   <= '0;
                repeating <= 1'b0;
                oPress    <= button_next & ~oButton_state;
            end else if (rpt_cnt == rpt_last) begin
                rpt_cnt   <= '0;
                repeating <= 1'b1;
                oPress    <= oButton_state;
            end else begin
                if (rpt_cnt != CNT_MAX) begin
                    rpt_cnt <= rpt_cnt + CNT_ONE;
                end
                oPress <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_touch_button_sequencer.sv
// ---------------------------------------------------------------------------
// tb_touch_button_sequencer
//
// Outputs are logged once per cycle on the falling edge. The reference model
// keeps the list of captured samples (time, finger count, zone hits) and
// derives expected outputs for any cycle from elapsed-time arithmetic on
// that list.
// ---------------------------------------------------------------------------
module tb_touch_button_sequencer;

    localparam int RT   = 16;
    localparam int RD   = 32;
    localparam int RP   = 8;
    localparam int CW   = 8;
    localparam int LOGN = 8192;

    logic       iCLK = 1'b0;
    logic       iRSTN;
    logic       iREADY;
    logic [9:0] ix1;
    logic [8:0] iy1;
    logic [9:0] ix2;
    logic [8:0] iy2;
    logic [1:0] itouch_count;
    logic [3:0] oButton_state;
    logic [3:0] oPress;
    logic       oTouch_active;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    int         q_t[$];
    logic [1:0] q_cnt[$];
    logic [2:0] q_hit[$];

    logic [3:0] log_btn[0:LOGN-1];
    logic [3:0] log_press[0:LOGN-1];
    logic       log_act[0:LOGN-1];

    touch_button_sequencer #(
        .RELEASE_TIMEOUT(RT),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .iCLK         (iCLK),
        .iRSTN        (iRSTN),
        .iREADY       (iREADY),
        .ix1          (ix1),
        .iy1          (iy1),
        .ix2          (ix2),
        .iy2          (iy2),
        .itouch_count (itouch_count),
        .oButton_state(oButton_state),
        .oPress       (oPress),
        .oTouch_active(oTouch_active)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    always @(negedge iCLK) begin
        if (cyc < LOGN) begin
            log_btn[cyc]   <= oButton_state;
            log_press[cyc] <= oPress;
            log_act[cyc]   <= oTouch_active;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] zone(input int x, input int y);
        logic [2:0] z;
        z[0] = (y > 400) && (x > 700) && (x < 800);
        z[1] = (y > 400) && (x > 600) && (x < 700);
        z[2] = (y > 400) && (x > 0)   && (x < 100);
        return z;
    endfunction

    function automatic int last_cap(input int t);
        for (int i = q_t.size() - 1; i >= 0; i--)
            if (q_t[i] <= t) return i;
        return -1;
    endfunction

    // Touching while the newest sample had fingers and is younger than RT.
    function automatic logic m_active(input int t);
        int i;
        if (t <= base) return 1'b0;
        i = last_cap(t);
        if (i < 0) return 1'b0;
        return (q_cnt[i] != 2'd0) && ((t - q_t[i]) < RT);
    endfunction

    function automatic logic [3:0] m_btn(input int t);
        int i;
        if (t <= base) return 4'b0000;
        if (m_active(t - 1) && m_active(t)) begin
            i = last_cap(t - 1);
            return {1'b0, q_hit[i]};
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] m_press(input int t);
        logic [3:0] b, p;
        int s, age;
        b = m_btn(t);
        p = m_btn(t - 1);
        if (b != p) return b & ~p;
        if (b == 4'b0000) return 4'b0000;
        s = t;
        while ((s - 1 > base) && (m_btn(s - 1) == b)) s--;
        age = t - s;
        if ((age >= RD) && (((age - RD) % RP) == 0)) return b;
        return 4'b0000;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_until(input int target);
        while (cyc < target) @(negedge iCLK);
    endtask

    // Entered on a falling edge; the capture edge is cyc+3.
    task automatic send_sample(input logic [1:0] cnt, input int x1, input int y1,
                               input int x2, input int y2);
        ix1 = 10'(x1); iy1 = 9'(y1); ix2 = 10'(x2); iy2 = 9'(y2);
        itouch_count = cnt;
        iREADY = 1'b1;
        q_t.push_back(cyc + 3);
        q_cnt.push_back(cnt);
        q_hit.push_back(((cnt != 2'd0) ? zone(x1, y1) : 3'b000) |
                        (cnt[1] ? zone(x2, y2) : 3'b000));
        repeat (3) @(negedge iCLK);
        iREADY = 1'b0;
        ix1 = 10'($urandom); iy1 = 9'($urandom);
        ix2 = 10'($urandom); iy2 = 9'($urandom);
        itouch_count = 2'($urandom);
        @(negedge iCLK);
    endtask

    function automatic int pick_x();
        int b[5] = '{0, 100, 600, 700, 800};
        case ($urandom_range(0, 5))
            0: return b[$urandom_range(0, 4)];
            1: return $urandom_range(701, 799);
            2: return $urandom_range(601, 699);
            3: return $urandom_range(1, 99);
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    function automatic int pick_y();
        case ($urandom_range(0, 4))
            0: return 400;
            1: return $urandom_range(0, 399);
            default: return $urandom_range(401, 511);
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        iRSTN = 1'b0; iREADY = 1'b0;
        ix1 = '0; iy1 = '0; ix2 = '0; iy2 = '0; itouch_count = '0;
        repeat (2) @(negedge iCLK);
        iREADY = 1'b1; itouch_count = 2'd1; ix1 = 10'd750; iy1 = 9'd450;
        repeat (3) @(negedge iCLK);
        checks++; if (oButton_state !== 4'b0000) begin failures++; $display("FAIL reset_btn got=%b exp=0000", oButton_state); end
        checks++; if (oPress !== 4'b0000) begin failures++; $display("FAIL reset_press got=%b exp=0000", oPress); end
        checks++; if (oTouch_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", oTouch_active); end
        iREADY = 1'b0;
        @(negedge iCLK);
        iRSTN = 1'b1;
        base = cyc;
        repeat (6) @(negedge iCLK);
        for (int t = base + 1; t < cyc; t++) begin
            checks++; if (log_btn[t] !== 4'b0000 || log_act[t] !== 1'b0 || log_press[t] !== 4'b0000) begin
                failures++; $display("FAIL post_reset_idle cyc=%0d got=%b/%b/%b exp=0000/0000/0", t, log_btn[t], log_press[t], log_act[t]);
            end
        end
    endtask

    task automatic test_single_press();
        int t0, e;
        t0 = cyc; e = cyc + 3;
        send_sample(2'd1, 750, 450, 650, 450);
        wait_until(e + 20);
        checks++; if (log_act[e] !== 1'b1) begin failures++; $display("FAIL single_active got=%b exp=1", log_act[e]); end
        checks++; if (log_btn[e + 1] !== 4'b0001) begin failures++; $display("FAIL single_btn got=%b exp=0001", log_btn[e + 1]); end
        checks++; if (log_press[e + 1] !== 4'b0001) begin failures++; $display("FAIL single_pulse got=%b exp=0001", log_press[e + 1]); end
        checks++; if (log_press[e + 2] !== 4'b0000) begin failures++; $display("FAIL single_pulse_len got=%b exp=0000", log_press[e + 2]); end
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL single_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL single_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL single_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_two_finger();
        int t0, e, e2, e3;
        t0 = cyc; e = cyc + 3;
        send_sample(2'd2, 50, 420, 650, 410);
        wait_until(e + 6);
        e2 = cyc + 3;
        send_sample(2'd1, 700, 450, 0, 0);
        wait_until(e2 + 6);
        e3 = cyc + 3;
        send_sample(2'd1, 750, 400, 0, 0);
        wait_until(e3 + 6);
        send_sample(2'd1, 650, 401, 0, 0);
        wait_until(cyc + 22);
        checks++; if (log_btn[e + 1] !== 4'b0110) begin failures++; $display("FAIL two_btn got=%b exp=0110", log_btn[e + 1]); end
        checks++; if (log_press[e + 1] !== 4'b0110) begin failures++; $display("FAIL two_pulse got=%b exp=0110", log_press[e + 1]); end
        checks++; if (log_btn[e2 + 1] !== 4'b0000) begin failures++; $display("FAIL bound_x700 got=%b exp=0000", log_btn[e2 + 1]); end
        checks++; if (log_btn[e3 + 1] !== 4'b0000) begin failures++; $display("FAIL bound_y400 got=%b exp=0000", log_btn[e3 + 1]); end
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL two_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL two_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL two_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_timeout();
        int t0, e;
        t0 = cyc; e = cyc + 3;
        send_sample(2'd1, 750, 450, 0, 0);
        wait_until(e + 22);
        checks++; if (log_act[e + RT - 1] !== 1'b1 || log_btn[e + RT - 1] !== 4'b0001) begin failures++; $display("FAIL timeout_early got=%b/%b exp=1/0001", log_act[e + RT - 1], log_btn[e + RT - 1]); end
        checks++; if (log_act[e + RT] !== 1'b0 || log_btn[e + RT] !== 4'b0000) begin failures++; $display("FAIL timeout_release got=%b/%b exp=0/0000", log_act[e + RT], log_btn[e + RT]); end
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL timeout_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL timeout_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL timeout_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_repeat();
        int t0, e, nxt;
        t0 = cyc; e = cyc + 3;
        for (int k = 0; k < 9; k++) begin
            nxt = cyc + 10;
            send_sample(2'd1, $urandom_range(1, 99), $urandom_range(401, 511), 750, 450);
            wait_until(nxt);
        end
        wait_until(e + 102);
        checks++; if (log_press[e + 1] !== 4'b0100) begin failures++; $display("FAIL repeat_first got=%b exp=0100", log_press[e + 1]); end
        checks++; if (log_press[e + 1 + RD - 1] !== 4'b0000) begin failures++; $display("FAIL repeat_early got=%b exp=0000", log_press[e + RD]); end
        checks++; if (log_press[e + 1 + RD] !== 4'b0100) begin failures++; $display("FAIL repeat_delay got=%b exp=0100", log_press[e + 1 + RD]); end
        checks++; if (log_press[e + 1 + RD + RP - 1] !== 4'b0000) begin failures++; $display("FAIL repeat_gap got=%b exp=0000", log_press[e + RD + RP]); end
        checks++; if (log_press[e + 1 + RD + RP] !== 4'b0100) begin failures++; $display("FAIL repeat_period got=%b exp=0100", log_press[e + 1 + RD + RP]); end
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL repeat_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL repeat_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL repeat_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_race();
        int t0, e, e2, e3;
        t0 = cyc; e = cyc + 3;
        send_sample(2'd1, 750, 450, 0, 0);
        wait_until(e + RT - 3);
        e2 = cyc + 3;
        send_sample(2'd1, 650, 450, 0, 0);
        wait_until(e2 + 6);
        e3 = cyc + 3;
        send_sample(2'd0, 750, 450, 50, 450);
        wait_until(e3 + 6);
        checks++; if (log_act[e + RT] !== 1'b1) begin failures++; $display("FAIL race_stay got=%b exp=1", log_act[e + RT]); end
        checks++; if (log_btn[e2 + 1] !== 4'b0010 || log_press[e2 + 1] !== 4'b0010) begin failures++; $display("FAIL race_update got=%b/%b exp=0010/0010", log_btn[e2 + 1], log_press[e2 + 1]); end
        checks++; if (log_act[e3] !== 1'b0 || log_btn[e3] !== 4'b0000) begin failures++; $display("FAIL count0_release got=%b/%b exp=0/0000", log_act[e3], log_btn[e3]); end
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL race_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL race_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL race_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_async_reset();
        int t0, e, r;
        t0 = cyc; e = cyc + 3;
        send_sample(2'd1, 40, 480, 0, 0);
        wait_until(e + 8);
        @(posedge iCLK);
        #2;
        iRSTN = 1'b0;
        #1;
        r = cyc;
        checks++; if (oButton_state !== 4'b0000 || oPress !== 4'b0000 || oTouch_active !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%b/%b/%b exp=0000/0000/0", oButton_state, oPress, oTouch_active);
        end
        checks++; if (log_btn[r - 1] !== 4'b0100) begin failures++; $display("FAIL pre_reset_hold got=%b exp=0100", log_btn[r - 1]); end
        for (int t = t0; t < r; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL prereset_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL prereset_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
        end
        repeat (2) @(negedge iCLK);
        iRSTN = 1'b1;
        base = cyc;
        q_t.delete(); q_cnt.delete(); q_hit.delete();
        e = cyc + 3;
        send_sample(2'd1, 40, 480, 0, 0);
        wait_until(e + 20);
        checks++; if (log_press[e + 1] !== 4'b0100) begin failures++; $display("FAIL fresh_press got=%b exp=0100", log_press[e + 1]); end
        for (int t = base + 1; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL postreset_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL postreset_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL postreset_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    task automatic test_random();
        int t0, reps, nxt, x1, y1, x2, y2;
        logic [1:0] cnt;
        t0 = cyc;
        for (int n = 0; n < 40; n++) begin
            cnt = ($urandom_range(0, 4) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            x1 = pick_x(); y1 = pick_y(); x2 = pick_x(); y2 = pick_y();
            reps = ($urandom_range(0, 4) == 0) ? 6 : $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                nxt = cyc + $urandom_range(8, 14);
                send_sample(cnt, x1, y1, x2, y2);
                wait_until(nxt);
            end
            wait_until(cyc + $urandom_range(0, 22));
        end
        wait_until(cyc + 20);
        for (int t = t0; t < cyc; t++) begin
            checks++; if (log_btn[t] !== m_btn(t)) begin failures++; $display("FAIL random_model_btn cyc=%0d got=%b exp=%b", t, log_btn[t], m_btn(t)); end
            checks++; if (log_press[t] !== m_press(t)) begin failures++; $display("FAIL random_model_press cyc=%0d got=%b exp=%b", t, log_press[t], m_press(t)); end
            checks++; if (log_act[t] !== m_active(t)) begin failures++; $display("FAIL random_model_act cyc=%0d got=%b exp=%b", t, log_act[t], m_active(t)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_two_finger();
        test_timeout();
        test_repeat();
        test_race();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/touch_button_sequencer.md
TOUCH_BUTTON_SEQUENCER -- requirements
Module: touch_button_sequencer

Interface
REQ-001 SHALL have parameter RELEASE_TIMEOUT, default 2_500_000: idle cycles without a panel sample before touch is declared released.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25_000_000: cycles of unchanged non-zero hold before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5_000_000: cycles between subsequent auto-repeats.
REQ-004 SHALL have parameter CNT_W, default 25: width of the internal timeout and repeat counters.
REQ-005 iCLK  input  1  single system clock; all logic on rising edge.
REQ-006 iRSTN  input  1  asynchronous, active-low reset.
REQ-007 iREADY  input  1  touch-panel sample strobe, asynchronous to iCLK.
REQ-008 ix1 input 10, iy1 input 9, ix2 input 10, iy2 input 9  finger 1 and finger 2 coordinates, valid when iREADY rises.
REQ-009 itouch_count  input  2  number of fingers in the sample.
REQ-010 oButton_state  output  4  {1'b0, up, left, right}, the held buttons.
REQ-011 oPress  output  4  one-cycle press/repeat pulses, same bit order; bit 3 is always 0.
REQ-012 oTouch_active  output  1  high while the FSM is in ACTIVE.

Function
REQ-013 SHALL pass iREADY through a 3-flop shift register ready_d; sample event = ready_d[1] & ~ready_d[2], asserted 2-3 cycles after iREADY rises.
REQ-014 SHALL capture ix1, iy1, ix2, iy2 and itouch_count into registers on the cycle of the sample event; ignore input changes between sample events.
REQ-015 SHALL compute hits from the captured values using strict inequalities: right 700<x<800, left 600<x<700, up 0<x<100, all with y>400; finger 1 valid if count!=0, finger 2 valid if count[1]; each button is the OR over both fingers.
REQ-016 SHALL implement a 2-state FSM: IDLE and ACTIVE.
REQ-017 IDLE->ACTIVE on a sample event with itouch_count!=0; release counter cleared.
REQ-018 ACTIVE: each sample event with count!=0 clears the release counter and updates the hits; otherwise the counter increments each cycle, saturating and never wrapping.
REQ-019 ACTIVE->IDLE on a sample event with count==0, or when the release counter equals RELEASE_TIMEOUT-1.
REQ-020 If a sample event and the timeout occur in the same cycle, the sample event SHALL win.
REQ-021 oButton_state SHALL equal the registered hits in ACTIVE and 4'b0 in IDLE; bit 3 always 0; latency is 1 cycle after capture.
REQ-022 oPress[i] SHALL pulse for exactly one cycle on each 0->1 transition of oButton_state[i].
REQ-023 Repeat counter SHALL clear whenever oButton_state changes or is zero, and otherwise increment.
REQ-024 When the repeat counter reaches REPEAT_DELAY-1, oPress SHALL pulse for all held bits; thereafter it SHALL pulse every REPEAT_PERIOD cycles while the hold is unchanged.
REQ-025 A button change during a repeat sequence SHALL restart the delay; newly set bits SHALL pulse once via REQ-022.
REQ-026 Any release (->IDLE) SHALL zero oButton_state in the next cycle and SHALL produce no oPress pulse.

Reset
REQ-027 While iRSTN=0: FSM=IDLE; ready_d, captured registers and counters =0; oButton_state=4'b0, oPress=4'b0, oTouch_active=0.
REQ-028 Reset SHALL take effect immediately, including mid-touch or mid-repeat; the first sample after deassertion SHALL be treated as a new press.

Verification (RELEASE_TIMEOUT=16, REPEAT_DELAY=32, REPEAT_PERIOD=8)
REQ-029 iREADY pulse with count=1, x1=750, y1=450 -> oButton_state=4'b0001, one oPress=4'b0001 pulse, oTouch_active=1.
REQ-030 Count=2, x1=50/y1=420, x2=650/y2=410 -> oButton_state=4'b0110; boundary x1=700 or y1=400 -> no hit.
REQ-031 Single sample, then no iREADY activity -> IDLE and oButton_state=0 exactly 16 cycles after capture; no oPress pulse.
REQ-032 Up held with samples every 10 cycles -> first repeat pulse 32 cycles after the press pulse, then pulses every 8 cycles.
REQ-033 Sample arriving on the timeout cycle -> stays ACTIVE; sample with count=0 -> immediate IDLE.
REQ-034 iRSTN low mid-hold -> all outputs 0 asynchronously; identical sample after release -> fresh oPress pulse.
